// File: rtl/icache_fill_ctrl_if.sv
// icache_fill_ctrl_if: miss, serializer, deserializer and fill-port bundle for the icache fill controller.
// master is the controller's view; slave is the view of the surrounding cache/bus logic.
interface icache_fill_ctrl_if #(
  parameter int PADDR_W = 15
);
  logic               miss_e;
  logic               miss_o;
  logic [PADDR_W-1:0] paddr_e;
  logic [PADDR_W-1:0] paddr_o;
  logic               flush;
  logic               ser_req;
  logic               ser_grant;
  logic               ser_valid;
  logic               ser_release;
  logic [PADDR_W-1:0] ser_paddr;
  logic [3:0]         ser_dest;
  logic               des_full;
  logic [PADDR_W-1:0] des_paddr;
  logic               des_read;
  logic               fill_we_e;
  logic               fill_we_o;
  logic [PADDR_W-1:0] fill_paddr;
  logic               fill_done_e;
  logic               fill_done_o;
  logic               busy;
  logic [7:0]         timeout_cnt;
  logic [7:0]         drop_cnt;

  modport master (
    input  miss_e, miss_o, paddr_e, paddr_o, flush, ser_grant, des_full, des_paddr,
    output ser_req, ser_valid, ser_release, ser_paddr, ser_dest, des_read,
           fill_we_e, fill_we_o, fill_paddr, fill_done_e, fill_done_o, busy,
           timeout_cnt, drop_cnt
  );

  modport slave (
    output miss_e, miss_o, paddr_e, paddr_o, flush, ser_grant, des_full, des_paddr,
    input  ser_req, ser_valid, ser_release, ser_paddr, ser_dest, des_read,
           fill_we_e, fill_we_o, fill_paddr, fill_done_e, fill_done_o, busy,
           timeout_cnt, drop_cnt
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: two-bank instruction-cache miss fill controller.
// Latches one miss per bank, services them round-robin over the serializer and writes the returned line.
module icache_fill_ctrl #(
  parameter int PADDR_W = 15,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  icache_fill_ctrl_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] FILL = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]         state;
  logic               pend_e;
  logic               pend_o;
  logic               rr;
  logic               cur_bank;
  logic [PADDR_W-1:0] addr_e;
  logic [PADDR_W-1:0] addr_o;
  logic [PADDR_W-1:0] cur_paddr;
  logic [7:0]         wait_cnt;
  logic [7:0]         timeout_cnt_q;
  logic [7:0]         drop_cnt_q;
  logic               pick_odd;
  logic               des_match;
  logic               des_drop;
  logic               flush_all;
  logic               flush_other;
  logic               clr_e;
  logic               clr_o;

  assign pick_odd    = pend_o && (!pend_e || rr);
  assign des_match   = (state == WAIT) && bus.des_full && (bus.des_paddr == cur_paddr);
  assign des_drop    = (state == WAIT) && bus.des_full && (bus.des_paddr != cur_paddr);
  assign flush_all   = bus.flush && ((state == IDLE) || (state == REQ));
  assign flush_other = bus.flush && !flush_all;

  // Once a request is on the bus a flush only spares the bank in flight; filling always retires its flag.
  assign clr_e = flush_all || (flush_other && cur_bank)  || ((state == FILL) && !cur_bank);
  assign clr_o = flush_all || (flush_other && !cur_bank) || ((state == FILL) && cur_bank);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_e <= 1'b0;
      pend_o <= 1'b0;
      addr_e <= '0;
      addr_o <= '0;
    end else begin
      if (bus.miss_e && !pend_e) begin
        pend_e <= 1'b1;
        addr_e <= bus.paddr_e;
      end
      if (bus.miss_o && !pend_o) begin
        pend_o <= 1'b1;
        addr_o <= bus.paddr_o;
      end
      if (clr_e) pend_e <= 1'b0;
      if (clr_o) pend_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr            <= 1'b0;
      cur_bank      <= 1'b0;
      cur_paddr     <= '0;
      wait_cnt      <= 8'd0;
      timeout_cnt_q <= 8'd0;
      drop_cnt_q    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.flush && (pend_e || pend_o)) begin
            cur_bank  <= pick_odd;
            cur_paddr <= pick_odd ? addr_o : addr_e;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.flush)          state <= IDLE;
          else if (bus.ser_grant) state <= SEND;
        end
        SEND: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (des_match) begin
            state <= FILL;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= REQ;
            if (timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FILL: begin
          rr    <= ~cur_bank;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (des_drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.ser_req     = (state == REQ);
  assign bus.ser_valid   = (state == SEND);
  assign bus.ser_release = (state == SEND);
  assign bus.ser_paddr   = (state == SEND) ? cur_paddr : '0;
  assign bus.ser_dest    = (state == SEND) ? {3'b000, cur_bank} : 4'b0000;
  assign bus.des_read    = (state == FILL) || des_drop;
  assign bus.fill_we_e   = (state == FILL) && !cur_bank;
  assign bus.fill_we_o   = (state == FILL) && cur_bank;
  assign bus.fill_done_e = (state == FILL) && !cur_bank;
  assign bus.fill_done_o = (state == FILL) && cur_bank;
  assign bus.fill_paddr  = (state == FILL) ? cur_paddr : '0;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_cnt = timeout_cnt_q;
  assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: scoreboard bench for icache_fill_ctrl.
// Expected fills are queued as misses are driven and popped whenever the DUT writes a line.
module tb_icache_fill_ctrl;
  localparam int PADDR_W = 15;

  typedef struct packed {
    logic               bank;
    logic [PADDR_W-1:0] paddr;
  } fill_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    total_checks = 0;
  int    bad_checks = 0;
  int    cycle_count = 0;
  int    fill_count = 0;
  int    last_fill_cycle = 0;
  int    miss_cycle = 0;
  fill_t exp_fill_q[$];
  fill_t mon_exp;

  icache_fill_ctrl_if #(.PADDR_W(PADDR_W)) bus ();

  icache_fill_ctrl #(.PADDR_W(PADDR_W), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every line write must match the oldest outstanding miss, with write enable and done on the same bank.
  always @(negedge clk) begin
    if (!reset && (bus.fill_we_e || bus.fill_we_o)) begin
      fill_count++;
      last_fill_cycle = cycle_count;
      if (exp_fill_q.size() == 0) begin
        checkOutput("unexpectedFill", 32'(bus.fill_paddr), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_fill_q.pop_front();
        checkOutput("fillWe", 32'({bus.fill_we_o, bus.fill_we_e}), mon_exp.bank ? 32'd2 : 32'd1);
        checkOutput("fillDone", 32'({bus.fill_done_o, bus.fill_done_e}), mon_exp.bank ? 32'd2 : 32'd1);
        checkOutput("fillPaddr", 32'(bus.fill_paddr), 32'(mon_exp.paddr));
        checkOutput("fillDesRead", 32'(bus.des_read), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic me, input logic mo,
                               input logic [PADDR_W-1:0] pe, input logic [PADDR_W-1:0] po);
    bus.miss_e  = me;
    bus.miss_o  = mo;
    bus.paddr_e = pe;
    bus.paddr_o = po;
    miss_cycle  = cycle_count;
    tick();
    bus.miss_e = 1'b0;
    bus.miss_o = 1'b0;
  endtask

  task automatic pushExp(input logic bank, input logic [PADDR_W-1:0] paddr);
    fill_t e;
    e.bank  = bank;
    e.paddr = paddr;
    exp_fill_q.push_back(e);
  endtask

  task automatic waitReq(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.ser_req) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic grantAfter(input int delay);
    repeat (delay) begin
      @(negedge clk);
      checkOutput("reqHeld", 32'(bus.ser_req), 32'd1);
    end
    bus.ser_grant = 1'b1;
    @(posedge clk);
    #1;
    bus.ser_grant = 1'b0;
  endtask

  task automatic checkSend(input logic [PADDR_W-1:0] paddr, input logic [3:0] dest);
    @(negedge clk);
    checkOutput("sendStrobes", 32'({bus.ser_valid, bus.ser_release, bus.ser_req}), 32'b110);
    checkOutput("sendPaddr", 32'(bus.ser_paddr), 32'(paddr));
    checkOutput("sendDest", 32'(bus.ser_dest), 32'(dest));
  endtask

  task automatic respond(input logic [PADDR_W-1:0] paddr, input bit mismatch_first, input int exp_drop);
    @(posedge clk);
    #1;
    if (mismatch_first) begin
      bus.des_full  = 1'b1;
      bus.des_paddr = 15'h7FFF;
      @(negedge clk);
      checkOutput("dropRead", 32'(bus.des_read), 32'd1);
      @(posedge clk);
      #1;
      bus.des_full = 1'b0;
      @(negedge clk);
      checkOutput("dropReadEnd", 32'(bus.des_read), 32'd0);
      checkOutput("dropCnt", 32'(bus.drop_cnt), 32'(exp_drop));
      checkOutput("dropStayWait", 32'(dut.state), 32'd3);
      @(posedge clk);
      #1;
    end
    bus.des_full  = 1'b1;
    bus.des_paddr = paddr;
    @(posedge clk);
    #1;
    bus.des_full = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Ctl"}, 32'({bus.ser_req, bus.ser_valid, bus.ser_release, bus.des_read, bus.fill_we_e,
                                  bus.fill_we_o, bus.fill_done_e, bus.fill_done_o, bus.busy}), 32'd0);
    checkOutput({tag, "Paddr"}, 32'(bus.ser_paddr | bus.fill_paddr), 32'd0);
    checkOutput({tag, "Dest"}, 32'(bus.ser_dest), 32'd0);
    checkOutput({tag, "Cnt"}, 32'({bus.timeout_cnt, bus.drop_cnt}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int f0;
    bus.miss_e = 1'b0; bus.miss_o = 1'b0; bus.paddr_e = '0; bus.paddr_o = '0; bus.flush = 1'b0;
    bus.ser_grant = 1'b0; bus.des_full = 1'b0; bus.des_paddr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    $display("[TB] single even miss");
    f0 = fill_count;
    applyStimulus(1'b1, 1'b0, 15'h0123, 15'h0000);
    pushExp(1'b0, 15'h0123);
    waitReq("reqEven", 20);
    grantAfter(2);
    checkSend(15'h0123, 4'b0000);
    respond(15'h0123, 1'b0, 0);
    tick();
    @(negedge clk);
    checkOutput("singlePulse", 32'(fill_count - f0), 32'd1);
    checkOutput("doneEnds", 32'({bus.fill_done_e, bus.busy}), 32'd0);
    tick();

    $display("[TB] odd miss latency");
    applyStimulus(1'b0, 1'b1, 15'h0000, 15'h0456);
    pushExp(1'b1, 15'h0456);
    waitReq("reqOdd", 20);
    grantAfter(0);
    checkSend(15'h0456, 4'b0001);
    respond(15'h0456, 1'b0, 0);
    checkOutput("latency", 32'(last_fill_cycle - miss_cycle), 32'd5);
    tick();

    $display("[TB] simultaneous misses");
    applyStimulus(1'b1, 1'b1, 15'h0010, 15'h0011);
    pushExp(1'b0, 15'h0010);
    pushExp(1'b1, 15'h0011);
    waitReq("reqBothE", 20);
    grantAfter(1);
    checkSend(15'h0010, 4'b0000);
    respond(15'h0010, 1'b0, 0);
    tick();
    waitReq("reqBothO", 20);
    grantAfter(1);
    checkSend(15'h0011, 4'b0001);
    respond(15'h0011, 1'b0, 0);
    tick();
    @(negedge clk);
    checkOutput("rrAfterBoth", 32'(dut.rr), 32'd0);
    tick();

    $display("[TB] mismatched response dropped");
    applyStimulus(1'b1, 1'b0, 15'h0200, 15'h0000);
    pushExp(1'b0, 15'h0200);
    waitReq("reqDrop", 20);
    grantAfter(0);
    checkSend(15'h0200, 4'b0000);
    respond(15'h0200, 1'b1, 1);
    tick();

    $display("[TB] response timeout");
    applyStimulus(1'b0, 1'b1, 15'h0000, 15'h0333);
    pushExp(1'b1, 15'h0333);
    waitReq("reqTimeout", 20);
    grantAfter(0);
    checkSend(15'h0333, 4'b0001);
    waitReq("timeoutReissue", 300);
    checkOutput("timeoutCnt", 32'(bus.timeout_cnt), 32'd1);
    grantAfter(0);
    checkSend(15'h0333, 4'b0001);
    respond(15'h0333, 1'b0, 1);
    tick();

    $display("[TB] flush in REQ");
    f0 = fill_count;
    applyStimulus(1'b1, 1'b1, 15'h0050, 15'h0051);
    waitReq("reqFlush", 20);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flushReqDrop", 32'({bus.ser_req, bus.busy}), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("flushStaysIdle", 32'(bus.busy), 32'd0);
    checkOutput("flushNoFill", 32'(fill_count - f0), 32'd0);
    tick();

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b0, 15'h0444, 15'h0000);
    waitReq("reqReset", 20);
    grantAfter(0);
    checkSend(15'h0444, 4'b0000);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("midReset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 15'h0000, 15'h0555);
    pushExp(1'b1, 15'h0555);
    waitReq("reqAfterReset", 20);
    grantAfter(1);
    checkSend(15'h0555, 4'b0001);
    respond(15'h0555, 1'b0, 0);
    tick();

    $display("[TB] drop counter saturation");
    applyStimulus(1'b1, 1'b0, 15'h0666, 15'h0000);
    pushExp(1'b0, 15'h0666);
    bus.ser_grant = 1'b1;
    bus.des_full  = 1'b1;
    bus.des_paddr = 15'h7FFF;
    repeat (600) tick();
    checkOutput("dropSat", 32'(bus.drop_cnt), 32'hFF);
    f0 = fill_count;
    bus.des_paddr = 15'h0666;
    for (int i = 0; i < 300 && fill_count == f0; i++) @(negedge clk);
    checkOutput("satFill", 32'(fill_count - f0), 32'd1);
    #1;
    bus.ser_grant = 1'b0;
    bus.des_full  = 1'b0;
    repeat (3) tick();
    checkOutput("dropSatHold", 32'(bus.drop_cnt), 32'hFF);

    checkOutput("scoreboardEmpty", 32'(exp_fill_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end
endmodule
